// File: rtl/count_snapshot_fifo_if.sv
// Read-side valid/ready channel of count_snapshot_fifo.
// The FIFO drives data and valid, and the reader drives ready.
interface count_snapshot_fifo_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/count_snapshot_fifo.sv
// Captures the live counter value on snap into a small FIFO and hands it to a valid/ready reader.
// Optional macro SNAP_DROP_CNT_EN adds a saturating 8-bit count of dropped captures (drop_cnt).
module count_snapshot_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     count,
    input  logic                 snap,
    count_snapshot_fifo_if.master rd,
    output logic [AW:0]          level,
    output logic                 full,
    output logic                 empty,
    output logic                 overflow,
    input  logic                 clr_ovf
`ifdef SNAP_DROP_CNT_EN
    ,
    output logic [7:0]           drop_cnt
`endif
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_level;
    logic             r_overflow;

    logic w_full;
    logic w_empty;
    logic w_valid;
    logic w_push;
    logic w_pop;
    logic w_drop;

    assign w_full  = (r_level == (AW+1)'(DEPTH));
    assign w_empty = (r_level == '0);
    assign w_valid = ~w_empty;
    assign w_pop   = w_valid & rd.out_ready;
    assign w_push  = snap & (~w_full | w_pop);
    assign w_drop  = snap & w_full & ~w_pop;

    // Read is a plain mux off registered state, so snap/count never reach out_data in the same cycle.
    assign rd.out_data  = w_valid ? r_mem[r_rd_ptr] : '0;
    assign rd.out_valid = w_valid;
    assign level        = r_level;
    assign full         = w_full;
    assign empty        = w_empty;
    assign overflow     = r_overflow;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= count;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + (AW+1)'(1);
                2'b01:   r_level <= r_level - (AW+1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // A clear takes priority over a drop arriving in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (clr_ovf) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end
    end

`ifdef SNAP_DROP_CNT_EN
    logic [7:0] r_drop_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_drop_cnt <= '0;
        end else if (clr_ovf) begin
            r_drop_cnt <= '0;
        end else if (w_drop && (r_drop_cnt != 8'hFF)) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end

    assign drop_cnt = r_drop_cnt;
`endif

endmodule
